// File: rtl/sudoku_pkg.sv
// Shared types, width helpers and field layout for the Sudoku grid checker.
// A row word is {wp[N-1:0], blank[N-1:0], digits[N*DIGW-1:0]}.
package sudoku_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int DIG_OFS = 0;

  function automatic int ADDRW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int WORDW(input int n, input int digw);
    return 2 * n + n * digw;
  endfunction

  function automatic int BLANK_OFS(input int n, input int digw);
    return n * digw;
  endfunction

  function automatic int WP_OFS(input int n, input int digw);
    return n * digw + n;
  endfunction

  function automatic int box_index(input int r, input int c, input int box);
    return (r / box) * box + c / box;
  endfunction

endpackage

// File: rtl/sudoku_grid_checker_if.sv
// Control, RAM read port and result bundle between host/RAM and the checker.
interface sudoku_grid_checker_if #(
  parameter int BOX  = 2,
  parameter int DIGW = 4
);
  import sudoku_pkg::*;

  localparam int N  = BOX * BOX;
  localparam int AW = ADDRW(N);
  localparam int WW = WORDW(N, DIGW);

  logic          START;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] RamAddr;
  logic [WW-1:0] RamDat;
  logic          gameComplete;
  logic          gridFull;
  logic [N-1:0]  errRow;
  logic [N-1:0]  errCol;
  logic [N-1:0]  errBox;

  modport master (
    output START, RamDat,
    input  BUSY, DONE, RamAddr, gameComplete, gridFull, errRow, errCol, errBox
  );

  modport slave (
    input  START, RamDat,
    output BUSY, DONE, RamAddr, gameComplete, gridFull, errRow, errCol, errBox
  );

endinterface

// File: rtl/sudoku_cell_decoder.sv
// Turns one cell (digit, blank) into a one-hot digit-presence vector;
// blank or out-of-range digits contribute nothing.
module sudoku_cell_decoder #(
  parameter int N    = 4,
  parameter int DIGW = 4
) (
  input  logic [DIGW-1:0] digit_i,
  input  logic            blank_i,
  output logic [N-1:0]    onehot_o
);

  // Digit d in 1..N maps to bit d-1
  always_comb begin
    onehot_o = '0;
    if (!blank_i && (digit_i >= DIGW'(1)) && (digit_i <= DIGW'(N))) begin
      onehot_o = {{(N-1){1'b0}}, 1'b1} << (digit_i - DIGW'(1));
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/sudoku_grid_checker.sv
// Streams a Sudoku grid row by row from RAM and accumulates row/column/box
// digit-presence masks to report completion and per-group errors.
module sudoku_grid_checker
  import sudoku_pkg::*;
#(
  parameter int BOX    = 2,
  parameter int DIGW   = 4,
  parameter int RD_LAT = 1,
  parameter int AUTO   = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  sudoku_grid_checker_if.slave   bus
);

  localparam int N    = BOX * BOX;
  localparam int AW   = ADDRW(N);
  localparam int BOFS = BLANK_OFS(N, DIGW);

  state_e                state_q;
  logic [AW-1:0]         addr_q;
  logic                  busy_q, done_q;
  logic [RD_LAT-1:0]     vld_q;
  logic [AW-1:0]         row_q [RD_LAT];
  logic [N-1:0][N-1:0]   col_mask_q, col_mask_d, box_mask_q, box_mask_d;
  logic [N-1:0]          row_err_q, row_err_d;
  logic                  full_q, full_d;
  logic                  complete_out_q, full_out_q;
  logic [N-1:0]          err_row_q, err_col_q, err_box_q;
  logic [N-1:0]          err_col_s, err_box_s, row_or_s, blank_s;
  logic [N-1:0]          onehot_s [N];
  logic                  beat_vld_s;
  logic [AW-1:0]         beat_row_s;

  assign blank_s    = bus.RamDat[BOFS +: N];
  assign beat_vld_s = vld_q[RD_LAT-1];
  assign beat_row_s = row_q[RD_LAT-1];

  for (genvar c = 0; c < N; c++) begin : g_dec
    sudoku_cell_decoder #(.N(N), .DIGW(DIGW)) u_dec (
      .digit_i  (bus.RamDat[DIG_OFS + c*DIGW +: DIGW]),
      .blank_i  (blank_s[c]),
      .onehot_o (onehot_s[c])
    );
  end

  // Union of all digits present in the current beat
  always_comb begin
    row_or_s = '0;
    for (int c = 0; c < N; c++) begin
      row_or_s = row_or_s | onehot_s[c];
    end
  end

  // Fold a valid beat into the row error, column and box masks
  always_comb begin
    col_mask_d = col_mask_q;
    box_mask_d = box_mask_q;
    row_err_d  = row_err_q;
    full_d     = full_q;
    if (beat_vld_s) begin
      row_err_d[beat_row_s] = (row_or_s != {N{1'b1}});
      full_d                = full_q & ~(|blank_s);
      for (int c = 0; c < N; c++) begin
        col_mask_d[c] = col_mask_d[c] | onehot_s[c];
        for (int b = 0; b < N; b++) begin
          box_mask_d[b] = box_mask_d[b] |
              ((box_index(int'(beat_row_s), c, BOX) == b) ? onehot_s[c] : {N{1'b0}});
        end
      end
    end else begin
      full_d = full_q;
    end
  end

  // A column or box is wrong unless every digit showed up
  always_comb begin
    err_col_s = '0;
    err_box_s = '0;
    for (int g = 0; g < N; g++) begin
      err_col_s[g] = (col_mask_q[g] != {N{1'b1}});
      err_box_s[g] = (box_mask_q[g] != {N{1'b1}});
    end
  end

  // Scan FSM, read-valid pipeline, mask accumulation and result registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      vld_q          <= '0;
      for (int i = 0; i < RD_LAT; i++) row_q[i] <= '0;
      col_mask_q     <= '0;
      box_mask_q     <= '0;
      row_err_q      <= '0;
      full_q         <= 1'b0;
      complete_out_q <= 1'b0;
      full_out_q     <= 1'b0;
      err_row_q      <= '0;
      err_col_q      <= '0;
      err_box_q      <= '0;
    end else begin
      vld_q[0] <= (state_q == ST_SCAN);
      row_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        row_q[i] <= row_q[i-1];
      end
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            state_q    <= ST_SCAN;
            addr_q     <= '0;
            busy_q     <= 1'b1;
            col_mask_q <= '0;
            box_mask_q <= '0;
            row_err_q  <= '0;
            full_q     <= 1'b1;
          end
        end
        ST_SCAN: begin
          col_mask_q <= col_mask_d;
          box_mask_q <= box_mask_d;
          row_err_q  <= row_err_d;
          full_q     <= full_d;
          if (addr_q == AW'(N-1)) begin
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        ST_DRAIN: begin
          col_mask_q <= col_mask_d;
          box_mask_q <= box_mask_d;
          row_err_q  <= row_err_d;
          full_q     <= full_d;
          // Last beat was folded in on the previous edge once the pipe is empty
          if (vld_q == '0) begin
            state_q        <= ST_FINISH;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            err_row_q      <= row_err_q;
            err_col_q      <= err_col_s;
            err_box_q      <= err_box_s;
            full_out_q     <= full_q;
            complete_out_q <= full_q && (row_err_q == '0) &&
                              (err_col_s == '0) && (err_box_s == '0);
          end
        end
        ST_FINISH: begin
          done_q <= 1'b0;
          if (AUTO != 0) begin
            state_q    <= ST_SCAN;
            addr_q     <= '0;
            busy_q     <= 1'b1;
            col_mask_q <= '0;
            box_mask_q <= '0;
            row_err_q  <= '0;
            full_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;
  assign bus.RamAddr      = addr_q;
  assign bus.gameComplete = complete_out_q;
  assign bus.gridFull     = full_out_q;
  assign bus.errRow       = err_row_q;
  assign bus.errCol       = err_col_q;
  assign bus.errBox       = err_box_q;

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Directed bench: a 4x4 checker (RD_LAT=1) and a 9x9 auto-restarting checker (RD_LAT=2).
module tb_sudoku_grid_checker;
  import sudoku_pkg::*;

  localparam int W0 = WORDW(4, 4);
  localparam int W1 = WORDW(9, 4);

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  int   nvec = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  sudoku_grid_checker_if #(.BOX(2), .DIGW(4)) bus0();
  sudoku_grid_checker_if #(.BOX(3), .DIGW(4)) bus1();

  sudoku_grid_checker #(.BOX(2), .DIGW(4), .RD_LAT(1), .AUTO(0)) u_dut0 (
    .CLK(clk), .RST_N(rst0_n), .bus(bus0.slave));
  sudoku_grid_checker #(.BOX(3), .DIGW(4), .RD_LAT(2), .AUTO(1)) u_dut1 (
    .CLK(clk), .RST_N(rst1_n), .bus(bus1.slave));

  logic [W0-1:0] mem0 [4];
  logic [W0-1:0] pipe0;
  logic [W1-1:0] mem1 [9];
  logic [W1-1:0] p1a, p1b;

  always @(posedge clk) pipe0 <= mem0[bus0.RamAddr];
  always @(posedge clk) begin
    p1a <= mem1[bus1.RamAddr];
    p1b <= p1a;
  end
  assign bus0.RamDat = pipe0;
  assign bus1.RamDat = p1b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res0(input string tag, input logic gc, input logic gf,
                          input logic [3:0] er, input logic [3:0] ec, input logic [3:0] eb);
    chk({tag, ".gameComplete"}, bus0.gameComplete, gc);
    chk({tag, ".gridFull"}, bus0.gridFull, gf);
    chk({tag, ".errRow"}, bus0.errRow, er);
    chk({tag, ".errCol"}, bus0.errCol, ec);
    chk({tag, ".errBox"}, bus0.errBox, eb);
  endtask

  // Start a 4x4 scan, optionally re-pulse START in scan cycle 2, and expect DONE in cycle 6
  task automatic run0(input string tag, input bit repulse);
    int lat;
    int extra;
    @(negedge clk) bus0.START = 1'b1;
    @(negedge clk) bus0.START = 1'b0;
    chk({tag, ".busy0"}, bus0.BUSY, 1'b1);
    lat = 0;
    while (!bus0.DONE && lat < 40) begin
      if (lat < 4) chk({tag, ".addr"}, bus0.RamAddr, lat);
      bus0.START = (repulse && lat == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    bus0.START = 1'b0;
    chk({tag, ".latency"}, lat, 6);
    chk({tag, ".busy_done"}, bus0.BUSY, 1'b0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.DONE) extra++;
    end
    chk({tag, ".extra_done"}, extra, 0);
  endtask

  task automatic load_solved0();
    mem0[0] = {4'hA, 4'h0, 16'h4321};
    mem0[1] = {4'h5, 4'h0, 16'h2143};
    mem0[2] = {4'h0, 4'h0, 16'h3412};
    mem0[3] = {4'hF, 4'h0, 16'h1234};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int per;
    int quiet;
    logic [W1-1:0] w;
    bus0.START = 1'b0;
    bus1.START = 1'b0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    load_solved0();
    for (int r = 0; r < 9; r++) begin
      w = '0;
      for (int c = 0; c < 9; c++) w[c*4 +: 4] = 4'(((r*3 + r/3 + c) % 9) + 1);
      mem1[r] = w;
    end
    repeat (3) @(negedge clk);
    chk("reset.busy", bus0.BUSY, 1'b0);
    chk("reset.done", bus0.DONE, 1'b0);
    chk("reset.addr", bus0.RamAddr, 2'd0);
    chk_res0("reset", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    run0("solved", 1'b0);
    chk_res0("solved", 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);

    mem0[1] = {4'h0, 4'h0, 16'h4321};
    run0("dup_row", 1'b0);
    chk_res0("dup_row", 1'b0, 1'b1, 4'h0, 4'hF, 4'b0011);

    load_solved0();
    mem0[2] = {4'h0, 4'b0010, 16'h3412};
    run0("blank", 1'b0);
    chk_res0("blank", 1'b0, 1'b0, 4'b0100, 4'b0010, 4'b0100);

    load_solved0();
    mem0[3] = {4'h0, 4'h0, 16'h5230};
    run0("range", 1'b0);
    chk_res0("range", 1'b0, 1'b1, 4'b1000, 4'b1001, 4'b1100);

    load_solved0();
    run0("repulse", 1'b1);
    chk_res0("repulse", 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);

    // Abort a scan with reset in scan cycle 3
    @(negedge clk) bus0.START = 1'b1;
    @(negedge clk) bus0.START = 1'b0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b0;
    @(negedge clk) rst0_n = 1'b1;
    chk("abort.busy", bus0.BUSY, 1'b0);
    chk("abort.done", bus0.DONE, 1'b0);
    chk("abort.addr", bus0.RamAddr, 2'd0);
    chk_res0("abort", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    quiet = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus0.DONE) quiet++;
    end
    chk("abort.no_done", quiet, 0);
    run0("after_abort", 1'b0);
    chk_res0("after_abort", 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);

    // 9x9 auto-restarting checker
    @(negedge clk) bus1.START = 1'b1;
    @(negedge clk) bus1.START = 1'b0;
    lat = 0;
    while (!bus1.DONE && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("nine.latency", lat, 12);
    chk("nine.complete", bus1.gameComplete, 1'b1);
    chk("nine.full", bus1.gridFull, 1'b1);
    chk("nine.errRow", bus1.errRow, 9'h000);
    chk("nine.errCol", bus1.errCol, 9'h000);
    chk("nine.errBox", bus1.errBox, 9'h000);
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (!bus1.DONE && per < 60);
    chk("nine.period1", per, 13);
    chk("nine.complete2", bus1.gameComplete, 1'b1);
    w = mem1[4];
    w[16 +: 4] = 4'd0;
    mem1[4] = w;
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (!bus1.DONE && per < 60);
    chk("nine.period2", per, 13);
    chk("nine.bad.complete", bus1.gameComplete, 1'b0);
    chk("nine.bad.full", bus1.gridFull, 1'b1);
    chk("nine.bad.errRow", bus1.errRow, 9'h010);
    chk("nine.bad.errCol", bus1.errCol, 9'h010);
    chk("nine.bad.errBox", bus1.errBox, 9'h010);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/sudoku_grid_checker.md
Name: sudoku_grid_checker

Overview:
Parametrised, start-triggered Sudoku grid verifier for N×N grids, where N = BOX*BOX (BOX=2 gives 4x4; BOX=3 gives 9x9).
- Streams one grid row per cycle from the game RAM.
- Accumulates per-row, per-column and per-box digit-presence masks, so no full-grid buffer is needed.
- Reports overall completion, grid fullness and per-group error vectors.
- Sits between game-state RAM and display/win logic.

Parameters:
BOX, 2, box edge; N = BOX*BOX is a derived localparam.
DIGW, 4, bits per digit; must satisfy DIGW >= clog2(N+1).
RD_LAT, 1, RAM read latency in cycles; legal range 1..3.
AUTO, 0, 1 = restart a scan automatically after each DONE.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  synchronous active-low reset.
START  in  1  scan request; sampled only in IDLE.
BUSY  out  1  high while a scan is in progress.
DONE  out  1  one-cycle pulse when results update.
RamAddr  out  clog2(N)  row address.
RamDat  in  2N+N*DIGW  row word: {wp[N-1:0], blank[N-1:0], digits}; cell c at digits[c*DIGW +: DIGW].
gameComplete  out  1  grid full and every row, column and box is correct.
gridFull  out  1  no blank bits set in any row.
errRow  out  N  bit r set = row r incorrect.
errCol  out  N  bit c set = column c incorrect.
errBox  out  N  bit b set = box b incorrect; b = (r/BOX)*BOX + c/BOX.

Behaviour:
- Reset (RST_N low at a CLK edge): state IDLE; all outputs 0; RamAddr 0; masks and valid pipeline cleared. Reset mid-scan aborts the scan with no DONE.
- Cell decode:
  - A cell is valid when blank=0 and 1 <= digit <= N.
  - A valid cell yields onehot = 1 << (digit-1); otherwise all zeros.
  - wp bits are ignored.
- Group rule: a row, column or box is correct iff the OR of its N onehots equals all-ones. Duplicates, blanks and out-of-range digits therefore all flag errors.
- FSM states IDLE, SCAN, DRAIN, FINISH.
  - IDLE: on START=1, clear masks, go to SCAN. BUSY=1 from the next cycle.
  - SCAN: RamAddr = i in scan cycle i, for i = 0..N-1. After N cycles go to DRAIN.
  - DRAIN: wait until the last beat is consumed. RamAddr holds N-1.
  - FINISH (1 cycle): register all outputs; DONE=1, BUSY=0.
  - After FINISH: go to IDLE, or to SCAN with masks cleared when AUTO=1.
- Data capture:
  - Data for the address driven in cycle k is valid in cycle k+RD_LAT.
  - It is tracked by an RD_LAT-deep valid/row-index shift register.
  - On each valid beat:
    - row r error bit computed from that beat;
    - colMask[c] |= onehot_c;
    - boxMask[b] |= onehot_c;
    - fullAcc &= ~|blank.
- Latency: with START sampled at edge E0, DONE is high in the cycle following edge E0+N+RD_LAT+1. For BOX=2, RD_LAT=1 that is 6 cycles.
- Outputs hold their values between DONE pulses. They change only in FINISH or on reset.
- START while BUSY or in FINISH is ignored. It is not queued.
- Widths:
  - Mask arrays are N×N bits.
  - Row-index counters are clog2(N) bits.
  - RamAddr does not wrap during a scan.

Decomposition:
- Shared package sudoku_pkg:
  - FSM state enum.
  - Width helpers: ADDRW(N), WORDW(N,DIGW).
  - Field offset constants for blank, wp and digits.
  - box_index function.
- One sub-module, sudoku_cell_decoder: per cell, takes (digit, blank) and returns an N-bit onehot. It is instantiated N times.

Test Plan:
Common settings: BOX=2, RD_LAT=1, cells listed c0..c3.
1. Solved grid rows 1234 / 3412 / 2143 / 4321 (row0 digits=16'h4321), START pulse -> DONE at cycle 6; gameComplete=1, gridFull=1, errRow=errCol=errBox=0.
2. Same grid with row1 = 1234 -> gameComplete=0, errRow=0, errCol=4'hF, errBox=4'b0011, gridFull=1.
3. Solved grid with blank bit for row2 c1 -> gameComplete=0, gridFull=0, errRow=4'b0100, errCol=4'b0010, errBox=4'b0100.
4. Solved grid with row3 c0 = 0 and row3 c3 = 5 -> errRow=4'b1000, errCol=4'b1001, errBox=4'b1100, gridFull=1, gameComplete=0.
5. START re-pulsed in scan cycle 2 -> ignored, single DONE. RST_N low in scan cycle 3 -> no DONE, outputs 0, BUSY=0. New START afterwards -> DONE after 6 cycles.
6. BOX=3, RD_LAT=2, AUTO=1 with a known 9x9 solution -> DONE every 13 cycles, gameComplete=1. Corrupting RAM cell (4,4) between scans -> next DONE shows errRow[4], errCol[4], errBox[4] set.
